// File: rtl/spi_slv_shifter_if.sv
// Pin-side SPI signals plus the word-level tx/rx handshake of spi_slv_shifter.
interface spi_slv_shifter_if #(
   parameter int DATA_W = 8
);
   logic              sclk_in;
   logic              mosi_in;
   logic              cs_in;
   logic              miso_oe;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              frame_err;

   modport slave (
      input  sclk_in, mosi_in, cs_in, tx_data, tx_valid,
      output miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err
   );

   modport master (
      output sclk_in, mosi_in, cs_in, tx_data, tx_valid,
      input  miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err
   );
endinterface

// File: rtl/spi_slv_shifter.sv
// Oversampling SPI slave shifter with a one-entry tx buffer and open-drain miso.
// Optional macro SPI_SLV_ECHO_EN: an empty tx buffer sends the last received word instead of TX_DEFAULT.
module spi_slv_shifter #(
   parameter int                DATA_W     = 8,
   parameter bit                CPOL       = 1'b0,
   parameter bit                CPHA       = 1'b0,
   parameter logic [DATA_W-1:0] TX_DEFAULT = '1
) (
   input logic              clk,
   input logic              rst_b,
   spi_slv_shifter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   localparam int              CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] tx_buf;
   logic              tx_full;
   logic              miso_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              rx_valid_q;
   logic              frame_err_q;

   // [0]/[1] form the synchronizer, [2] is the history used for edge detection
   logic [2:0]        sclk_s;
   logic [2:0]        cs_s;
   logic [1:0]        mosi_s;

   logic sclk_rise, sclk_fall, lead_edge, trail_edge;
   logic sample_edge, shift_edge, cs_fall, cs_rise, word_done;
   logic [DATA_W-1:0] empty_word, load_word;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         sclk_s <= {3{CPOL}};
         cs_s   <= 3'b111;
         mosi_s <= 2'b11;
      end else begin
         sclk_s <= {sclk_s[1:0], bus.sclk_in};
         cs_s   <= {cs_s[1:0], bus.cs_in};
         mosi_s <= {mosi_s[0], bus.mosi_in};
      end
   end

   assign sclk_rise   = sclk_s[1] & ~sclk_s[2];
   assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
   assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
   assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;
   assign cs_fall     = ~cs_s[1] & cs_s[2];
   assign cs_rise     = cs_s[1] & ~cs_s[2];
   assign word_done   = sample_edge && (bit_cnt == LAST_BIT);

`ifdef SPI_SLV_ECHO_EN
   assign empty_word = rx_data_q;
`else
   assign empty_word = TX_DEFAULT;
`endif

   assign load_word = tx_full ? tx_buf : empty_word;

   // Main FSM; the tx buffer write sits above the case so a write landing in LOAD
   // with an empty buffer fills it for the following word only.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         tx_buf      <= '0;
         tx_full     <= 1'b0;
         miso_q      <= 1'b1;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;

         if (bus.tx_valid && !tx_full) begin
            tx_buf  <= bus.tx_data;
            tx_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               bit_cnt <= '0;
               miso_q  <= 1'b1;
               if (cs_fall) state <= LOAD;
            end

            LOAD: begin
               if (cs_rise) begin
                  state  <= IDLE;
                  miso_q <= 1'b1;
               end else begin
                  shift_reg <= load_word;
                  if (tx_full) tx_full <= 1'b0;
                  if (!CPHA) miso_q <= load_word[DATA_W-1];
                  state <= SHIFT;
               end
            end

            SHIFT: begin
               if (sample_edge) begin
                  shift_reg <= {shift_reg[DATA_W-2:0], mosi_s[1]};
                  if (word_done) begin
                     rx_data_q  <= {shift_reg[DATA_W-2:0], mosi_s[1]};
                     rx_valid_q <= 1'b1;
                     bit_cnt    <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else if (shift_edge && (CPHA || bit_cnt != '0)) begin
                  // With CPHA=0 the MSB went out at LOAD, so the last bit's trailing edge is skipped
                  miso_q <= shift_reg[DATA_W-1];
               end

               if (cs_rise) begin
                  state   <= IDLE;
                  miso_q  <= 1'b1;
                  bit_cnt <= '0;
                  if (!word_done && bit_cnt != '0) frame_err_q <= 1'b1;
               end else if (word_done) begin
                  state <= LOAD;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.miso_oe   = miso_q;
   assign bus.tx_ready  = ~tx_full;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.busy      = (state != IDLE);
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slv_shifter.sv
// Directed bench: dut_a runs CPOL=0/CPHA=0, dut_b runs CPOL=1/CPHA=1.
module tb_spi_slv_shifter;

`ifdef SPI_SLV_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   a_rxv_cnt = 0;
   int   a_fe_cnt = 0;
   int   b_fe_cnt = 0;
   logic [7:0] a_rx_last = '0;
   logic [7:0] b_rx_q[$];
   logic [7:0] a_last_rx = '0;

   spi_slv_shifter_if #(.DATA_W(8)) bus_a();
   spi_slv_shifter_if #(.DATA_W(8)) bus_b();

   spi_slv_shifter dut_a (.clk(clk), .rst_b(rst_b), .bus(bus_a));
   spi_slv_shifter #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut_b (.clk(clk), .rst_b(rst_b), .bus(bus_b));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus_a.rx_valid === 1'b1) begin
         a_rxv_cnt++;
         a_rx_last = bus_a.rx_data;
      end
      if (bus_a.frame_err === 1'b1) a_fe_cnt++;
      if (bus_b.rx_valid === 1'b1) b_rx_q.push_back(bus_b.rx_data);
      if (bus_b.frame_err === 1'b1) b_fe_cnt++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_tx_a(input logic [7:0] d);
      @(negedge clk);
      bus_a.tx_data = d;
      bus_a.tx_valid = 1'b1;
      @(negedge clk);
      bus_a.tx_valid = 1'b0;
   endtask

   task automatic write_tx_b(input logic [7:0] d);
      @(negedge clk);
      bus_b.tx_data = d;
      bus_b.tx_valid = 1'b1;
      @(negedge clk);
      bus_b.tx_valid = 1'b0;
   endtask

   task automatic xfer_a(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         bus_a.mosi_in = mo[7-i];
         wait_clks(8);
         mi[7-i] = bus_a.miso_oe;
         bus_a.sclk_in = 1'b1;
         wait_clks(8);
         bus_a.sclk_in = 1'b0;
      end
      wait_clks(8);
   endtask

   task automatic xfer_b(input logic [7:0] mo, output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < 8; i++) begin
         bus_b.sclk_in = 1'b0;
         bus_b.mosi_in = mo[7-i];
         wait_clks(8);
         mi[7-i] = bus_b.miso_oe;
         bus_b.sclk_in = 1'b1;
         wait_clks(8);
      end
   endtask

   task automatic cs_a(input logic level);
      bus_a.cs_in = level;
      wait_clks(8);
   endtask

   task automatic test_reset();
      bus_a.sclk_in = 1'b0; bus_a.mosi_in = 1'b1; bus_a.cs_in = 1'b1;
      bus_a.tx_data = '0;   bus_a.tx_valid = 1'b0;
      bus_b.sclk_in = 1'b1; bus_b.mosi_in = 1'b1; bus_b.cs_in = 1'b1;
      bus_b.tx_data = '0;   bus_b.tx_valid = 1'b0;
      rst_b = 1'b0;
      wait_clks(3);
      rst_b = 1'b1;
      wait_clks(2);
      n_checks++; if (bus_a.miso_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_miso_oe: got %b want 1", bus_a.miso_oe); end
      n_checks++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx_ready: got %b want 1", bus_a.tx_ready); end
      n_checks++; if (bus_a.rx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rx_data: got %h want 00", bus_a.rx_data); end
      n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", bus_a.busy); end
      n_checks++; if (bus_b.miso_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_b_miso_oe: got %b want 1", bus_b.miso_oe); end
      for (int i = 0; i < 8; i++) begin
         bus_a.sclk_in = ~bus_a.sclk_in;
         wait_clks(5);
      end
      wait_clks(5);
      n_checks++; if (a_rxv_cnt !== 0) begin n_fail++; $display("[TB] FAIL idle_sclk_rx_valid: got %0d pulses want 0", a_rxv_cnt); end
      n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_sclk_busy: got %b want 0", bus_a.busy); end
      n_checks++; if (bus_a.miso_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_sclk_miso_oe: got %b want 1", bus_a.miso_oe); end
      n_checks++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_sclk_tx_ready: got %b want 1", bus_a.tx_ready); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_mode0();
      logic [7:0] mi;
      int rx0;
      rx0 = a_rxv_cnt;
      write_tx_a(8'hA5);
      n_checks++; if (bus_a.tx_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mode0_tx_full: got %b want 0", bus_a.tx_ready); end
      cs_a(1'b0);
      n_checks++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mode0_tx_ready_after_load: got %b want 1", bus_a.tx_ready); end
      xfer_a(8'h3C, 8, mi);
      n_checks++; if (mi !== 8'hA5) begin n_fail++; $display("[TB] FAIL mode0_miso: got %h want a5", mi); end
      n_checks++; if (a_rxv_cnt !== rx0 + 1) begin n_fail++; $display("[TB] FAIL mode0_rx_pulses: got %0d want %0d", a_rxv_cnt - rx0, 1); end
      n_checks++; if (a_rx_last !== 8'h3C) begin n_fail++; $display("[TB] FAIL mode0_rx_data: got %h want 3c", a_rx_last); end
      cs_a(1'b1);
      a_last_rx = 8'h3C;
      n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mode0_busy_end: got %b want 0", bus_a.busy); end
      $display("[TB] test_mode0 done");
   endtask

   task automatic test_frame_err();
      logic [7:0] mi;
      logic [7:0] exp_tx;
      int rx0, fe0;
      rx0 = a_rxv_cnt;
      fe0 = a_fe_cnt;
      cs_a(1'b0);
      xfer_a(8'hB7, 5, mi);
      cs_a(1'b1);
      n_checks++; if (a_fe_cnt !== fe0 + 1) begin n_fail++; $display("[TB] FAIL frame_err_pulses: got %0d want 1", a_fe_cnt - fe0); end
      n_checks++; if (a_rxv_cnt !== rx0) begin n_fail++; $display("[TB] FAIL frame_err_no_rx: got %0d pulses want 0", a_rxv_cnt - rx0); end
      n_checks++; if (bus_a.miso_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL frame_err_miso_oe: got %b want 1", bus_a.miso_oe); end
      n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL frame_err_busy: got %b want 0", bus_a.busy); end
      exp_tx = ECHO ? a_last_rx : 8'hFF;
      cs_a(1'b0);
      xfer_a(8'hC3, 8, mi);
      cs_a(1'b1);
      n_checks++; if (mi !== exp_tx) begin n_fail++; $display("[TB] FAIL frame_err_next_miso: got %h want %h", mi, exp_tx); end
      n_checks++; if (a_rx_last !== 8'hC3) begin n_fail++; $display("[TB] FAIL frame_err_next_rx: got %h want c3", a_rx_last); end
      n_checks++; if (a_fe_cnt !== fe0 + 1) begin n_fail++; $display("[TB] FAIL frame_err_next_no_err: got %0d want 1", a_fe_cnt - fe0); end
      a_last_rx = 8'hC3;
      $display("[TB] test_frame_err done");
   endtask

   task automatic test_load_collision();
      logic [7:0] m1, m2;
      logic [7:0] exp_tx;
      int rx0;
      rx0 = a_rxv_cnt;
      exp_tx = ECHO ? a_last_rx : 8'hFF;
      bus_a.cs_in = 1'b0;
      for (int k = 0; k < 20 && bus_a.busy !== 1'b1; k++) @(negedge clk);
      n_checks++;
      if (bus_a.busy !== 1'b1) begin
         n_fail++; $display("[TB] FAIL collision_load_timeout: busy %b want 1", bus_a.busy);
      end
      bus_a.tx_data = 8'h6B;
      bus_a.tx_valid = 1'b1;
      @(negedge clk);
      bus_a.tx_valid = 1'b0;
      n_checks++; if (bus_a.tx_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL collision_tx_ready: got %b want 0", bus_a.tx_ready); end
      wait_clks(6);
      xfer_a(8'h11, 8, m1);
      xfer_a(8'h22, 8, m2);
      cs_a(1'b1);
      n_checks++; if (m1 !== exp_tx) begin n_fail++; $display("[TB] FAIL collision_word1_miso: got %h want %h", m1, exp_tx); end
      n_checks++; if (m2 !== 8'h6B) begin n_fail++; $display("[TB] FAIL collision_word2_miso: got %h want 6b", m2); end
      n_checks++; if (a_rxv_cnt !== rx0 + 2) begin n_fail++; $display("[TB] FAIL collision_rx_pulses: got %0d want 2", a_rxv_cnt - rx0); end
      n_checks++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL collision_tx_ready_end: got %b want 1", bus_a.tx_ready); end
      a_last_rx = 8'h22;
      $display("[TB] test_load_collision done");
   endtask

   task automatic test_echo();
      logic [7:0] m1, m2;
      logic [7:0] exp1, exp2;
      exp1 = ECHO ? a_last_rx : 8'hFF;
      exp2 = ECHO ? 8'h5A : 8'hFF;
      cs_a(1'b0);
      xfer_a(8'h5A, 8, m1);
      cs_a(1'b1);
      cs_a(1'b0);
      xfer_a(8'h00, 8, m2);
      cs_a(1'b1);
      n_checks++; if (m1 !== exp1) begin n_fail++; $display("[TB] FAIL echo_word1_miso: got %h want %h", m1, exp1); end
      n_checks++; if (m2 !== exp2) begin n_fail++; $display("[TB] FAIL echo_word2_miso: got %h want %h", m2, exp2); end
      n_checks++; if (a_rx_last !== 8'h00) begin n_fail++; $display("[TB] FAIL echo_rx_data: got %h want 00", a_rx_last); end
      a_last_rx = 8'h00;
      $display("[TB] test_echo done");
   endtask

   task automatic test_back_to_back();
      logic [7:0] m1, m2;
      logic [7:0] exp2;
      logic [7:0] q0, q1;
      exp2 = ECHO ? 8'h12 : 8'hFF;
      b_rx_q.delete();
      write_tx_b(8'h81);
      bus_b.cs_in = 1'b0;
      wait_clks(8);
      xfer_b(8'h12, m1);
      xfer_b(8'h34, m2);
      wait_clks(2);
      bus_b.cs_in = 1'b1;
      wait_clks(8);
      q0 = (b_rx_q.size() > 0) ? b_rx_q[0] : 8'hxx;
      q1 = (b_rx_q.size() > 1) ? b_rx_q[1] : 8'hxx;
      n_checks++; if (m1 !== 8'h81) begin n_fail++; $display("[TB] FAIL b2b_word1_miso: got %h want 81", m1); end
      n_checks++; if (m2 !== exp2) begin n_fail++; $display("[TB] FAIL b2b_word2_miso: got %h want %h", m2, exp2); end
      n_checks++; if (b_rx_q.size() !== 2) begin n_fail++; $display("[TB] FAIL b2b_rx_pulses: got %0d want 2", b_rx_q.size()); end
      n_checks++; if (q0 !== 8'h12) begin n_fail++; $display("[TB] FAIL b2b_rx0: got %h want 12", q0); end
      n_checks++; if (q1 !== 8'h34) begin n_fail++; $display("[TB] FAIL b2b_rx1: got %h want 34", q1); end
      n_checks++; if (b_fe_cnt !== 0) begin n_fail++; $display("[TB] FAIL b2b_frame_err: got %0d want 0", b_fe_cnt); end
      n_checks++; if (bus_b.miso_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_miso_oe_end: got %b want 1", bus_b.miso_oe); end
      n_checks++; if (bus_b.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_busy_end: got %b want 0", bus_b.busy); end
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_async_reset();
      logic [7:0] mi;
      write_tx_a(8'h88);
      cs_a(1'b0);
      xfer_a(8'hFF, 3, mi);
      write_tx_a(8'h77);
      n_checks++; if (bus_a.miso_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_pre_miso: got %b want 0", bus_a.miso_oe); end
      n_checks++; if (bus_a.tx_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_pre_tx_ready: got %b want 0", bus_a.tx_ready); end
      #2;
      rst_b = 1'b0;
      #1;
      n_checks++; if (bus_a.miso_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_miso_oe: got %b want 1", bus_a.miso_oe); end
      n_checks++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_tx_ready: got %b want 1", bus_a.tx_ready); end
      n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_busy: got %b want 0", bus_a.busy); end
      n_checks++; if (bus_a.rx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL areset_rx_data: got %h want 00", bus_a.rx_data); end
      bus_a.cs_in = 1'b1;
      bus_a.sclk_in = 1'b0;
      wait_clks(2);
      rst_b = 1'b1;
      wait_clks(4);
      a_last_rx = 8'h00;
      $display("[TB] test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_frame_err();
      test_load_collision();
      test_echo();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
